keypad_scan: RTL
================

// Module: keypad_scan
// PURPOSE
//   Scans a 4x4 matrix keypad for the password-lock datapath. This is the input-side counterpart of the 7-seg display driver.
//   Drives one row low at a time, samples the columns and debounces.
//   Emits one 4-bit key code per press on a valid/ready handshake to the lock FSM.
// PARAMETERS
//   SCAN_DIV        100000  clk cycles per scan tick (1 ms at 100 MHz)
//   DEBOUNCE_TICKS  10      consecutive matching ticks needed to accept a press or release (>=1)
//   REPEAT_DELAY    500     ticks of hold before first auto-repeat (KEYPAD_REPEAT_EN only)
//   REPEAT_RATE     100     ticks between later repeats (KEYPAD_REPEAT_EN only)
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous reset, active low
//   col_in     in   4  keypad columns, pulled up; 0 = key closed on the driven row
//   row_out    out  4  keypad rows, one-hot active low
//   key_code   out  4  code = {row_idx[1:0], col_idx[1:0]}; idx = position of the 0 bit
//   key_valid  out  1  key_code holds an unconsumed key
//   key_ready  in   1  consumer accepts; transfer when key_valid & key_ready at posedge clk
//   key_held   out  1  a debounced key is currently pressed
//   overrun    out  1  sticky: a press was dropped because key_valid was still pending
// BEHAVIOUR
// - Reset: row_out=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0, FSM=SCAN, all counters 0.
// - col_in passes a 2-FF synchronizer (colq) before any use.
// - Tick generator: counter 0..SCAN_DIV-1; tick is a 1-clk pulse when the counter = SCAN_DIV-1.
// - Columns are sampled only on tick, at the end of the period the current row was driven.
// - "single" = colq has exactly one 0 bit. "idle" = colq == 4'hF.
// - FSM states and transitions (all evaluated on tick only):
//   SCAN:     single -> latch row/col, dcnt=1, go DEB_PRESS, row_out held.
//             Otherwise (idle or multi-column ghost) -> rotate row 1110->1101->1011->0111->1110.
//   DEB_PRESS: same single col -> dcnt++. Mismatch -> SCAN and rotate row.
//             When dcnt reaches DEBOUNCE_TICKS -> emit, key_held=1, go PRESSED.
//             With DEBOUNCE_TICKS=1 the emit happens on the SCAN detection tick.
//   PRESSED:  idle -> dcnt=1, go DEB_REL. Otherwise stay; any column change is ignored.
//   DEB_REL:  idle -> dcnt++. Not idle -> back to PRESSED.
//             When dcnt reaches DEBOUNCE_TICKS -> key_held=0, go SCAN, rotate row.
// - Emit: on the clk after the accepting tick.
//   If key_valid=0 or a transfer happens that same cycle: key_code <= code, key_valid <= 1.
//   Otherwise key_code is unchanged and overrun <= 1.
// - Handshake:
//   key_code is stable while key_valid=1.
//   A transfer with no simultaneous emit clears key_valid on the next clk.
//   overrun clears on the next transfer.
//   key_ready while key_valid=0 has no effect.
// - Only one key per press; no further emit until full release debounce (without macro).
// - Counters saturate: dcnt never exceeds DEBOUNCE_TICKS; the repeat counter reloads after each repeat.
// - rst_n low at any point (mid-debounce, pending valid) forces reset values immediately.
// CONFIGURATION
//   KEYPAD_REPEAT_EN defined:
//     In PRESSED, the same code is re-emitted after REPEAT_DELAY ticks of continuous hold, then every REPEAT_RATE ticks.
//     Repeat emits follow the emit/overrun rules above; the repeat counter resets on entry to DEB_REL.
//   Undefined: no repeat logic is synthesised; REPEAT_* are unused.
// TESTING  (SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, key_ready=1 unless stated)
// 1. Hold col_in=4'b1101 only while row_out=4'b1011.
//    -> key_valid=1 with key_code=4'h9 on the clk after the 3rd matching tick; one clk later key_valid=0.
//    key_held=1 until 3 idle ticks after release.
// 2. Close a key for 2 ticks, then open.
//    -> no key_valid; row_out resumes rotating from the next row.
// 3. col_in=4'b1100 on row 0.
//    -> no key_valid; row_out keeps rotating 1110->1101->...
// 4. key_ready=0: press key 4'h9, release, then press key 4'h2.
//    -> key_code stays 4'h9 and overrun=1.
//    Pulse key_ready for one clk -> key_valid=0, overrun=0.
// 5. Assert rst_n=0 during DEB_PRESS with key_valid=1.
//    -> row_out=1110, key_valid=0, key_held=0 asynchronously; no emit after rst_n is released while the key is still held,
//    until a fresh 3-tick debounce completes.
// 6. KEYPAD_REPEAT_EN, hold key 4'h9 for 12 ticks after acceptance.
//    -> emits at acceptance, +5, +7, +9, +11 ticks.
//    Without the macro -> one emit only.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and a valid/ready key-code output.
// Optional KEYPAD_REPEAT_EN: re-emit a held key after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
module keypad_scan #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int REPEAT_DELAY   = 500,
   parameter int REPEAT_RATE    = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_held,
   output logic       overrun
);
   localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;
   state_t        state_q;
   logic [3:0]    col_s_q, col_q, lat_q, emit_code;
   logic [DW-1:0] div_q;
   logic [CW-1:0] dcnt_q, dcnt_d;
   logic [1:0]    row_idx, col_idx;
   logic          tick, idle, single, same, done, xfer, emit, emit_rep;
   if (DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("keypad_scan: DEBOUNCE_TICKS, REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end
   always_comb begin
      tick      = div_q == DW'(SCAN_DIV - 1);
      idle      = col_q == 4'hF;
      single    = col_q inside {4'hE, 4'hD, 4'hB, 4'h7};
      col_idx   = !col_q[0] ? 2'd0 : !col_q[1] ? 2'd1 : !col_q[2] ? 2'd2 : 2'd3;
      row_idx   = !row_out[0] ? 2'd0 : !row_out[1] ? 2'd1 : !row_out[2] ? 2'd2 : 2'd3;
      dcnt_d    = dcnt_q + 1'b1;
      done      = dcnt_d == CW'(DEBOUNCE_TICKS);
      same      = single && col_idx == lat_q[1:0];
      xfer      = key_valid && key_ready;
      emit_code = state_q == SCAN ? {row_idx, col_idx} : lat_q;
      emit      = tick && ((state_q == SCAN && single && DEBOUNCE_TICKS == 1) ||
                           (state_q == DEB_PRESS && same && done) || emit_rep);
   end
`ifdef KEYPAD_REPEAT_EN
   localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          rep_q, rdone;
   always_comb begin
      rcnt_d   = rcnt_q + 1'b1;
      rdone    = rcnt_d == (rep_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY));
      emit_rep = state_q == PRESSED && !idle && rdone;
   end
   // Counter restarts whenever the key is not in steady hold, including entry to DEB_REL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt_q <= '0;
         rep_q  <= 1'b0;
      end else if (tick) begin
         if (state_q != PRESSED || idle) begin
            rcnt_q <= '0;
            rep_q  <= 1'b0;
         end else if (rdone) begin
            rcnt_q <= '0;
            rep_q  <= 1'b1;
         end else begin
            rcnt_q <= rcnt_d;
         end
      end
   end
`else
   assign emit_rep = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SCAN;
         col_s_q   <= 4'hF;
         col_q     <= 4'hF;
         div_q     <= '0;
         dcnt_q    <= '0;
         lat_q     <= 4'h0;
         row_out   <= 4'b1110;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         col_s_q <= col_in;
         col_q   <= col_s_q;
         div_q   <= tick ? '0 : div_q + 1'b1;
         if (emit && (!key_valid || xfer)) begin
            key_code  <= emit_code;
            key_valid <= 1'b1;
         end else if (xfer) begin
            key_valid <= 1'b0;
         end
         overrun <= xfer ? 1'b0 : overrun | (emit & key_valid);
         if (tick) begin
            case (state_q)
               SCAN: begin
                  if (single) begin
                     lat_q  <= {row_idx, col_idx};
                     dcnt_q <= CW'(1);
                     if (DEBOUNCE_TICKS == 1) begin
                        key_held <= 1'b1;
                        state_q  <= PRESSED;
                     end else begin
                        state_q <= DEB_PRESS;
                     end
                  end else begin
                     row_out <= {row_out[2:0], row_out[3]};
                  end
               end
               DEB_PRESS: begin
                  if (same) begin
                     dcnt_q <= dcnt_d;
                     if (done) begin
                        key_held <= 1'b1;
                        state_q  <= PRESSED;
                     end
                  end else begin
                     dcnt_q  <= '0;
                     state_q <= SCAN;
                     row_out <= {row_out[2:0], row_out[3]};
                  end
               end
               PRESSED: begin
                  if (idle) begin
                     dcnt_q <= CW'(1);
                     if (DEBOUNCE_TICKS == 1) begin
                        key_held <= 1'b0;
                        state_q  <= SCAN;
                        row_out  <= {row_out[2:0], row_out[3]};
                     end else begin
                        state_q <= DEB_REL;
                     end
                  end
               end
               default: begin
                  if (idle) begin
                     dcnt_q <= dcnt_d;
                     if (done) begin
                        key_held <= 1'b0;
                        state_q  <= SCAN;
                        row_out  <= {row_out[2:0], row_out[3]};
                     end
                  end else begin
                     state_q <= PRESSED;
                  end
               end
            endcase
         end
      end
   end
endmodule
